// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between two sources (A: ALU, B: load/long-latency) and the
// register file write port, plus the pipeline hold input.
interface regfile_wb_arbiter_if #(
  parameter int unsigned XLEN = 32
);
  logic            hold;
  logic            a_valid;
  logic            a_ready;
  logic [4:0]      a_rd;
  logic [XLEN-1:0] a_wd;
  logic            b_valid;
  logic            b_ready;
  logic [4:0]      b_rd;
  logic [XLEN-1:0] b_wd;
  logic            rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wd;
  logic            b_forced;

  // Sources and pipeline control side.
  modport master (
    output hold, a_valid, a_rd, a_wd, b_valid, b_rd, b_wd,
    input  a_ready, b_ready, rf_we, rf_rd, rf_wd, b_forced
  );

  // Arbiter side.
  modport slave (
    input  hold, a_valid, a_rd, a_wd, b_valid, b_rd, b_wd,
    output a_ready, b_ready, rf_we, rf_rd, rf_wd, b_forced
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between writeback sources A and B:
// fixed priority to A, with a starvation guard that forces a B grant.
module regfile_wb_arbiter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  regfile_wb_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             rf_we_q;
  logic [4:0]       rf_rd_q;
  logic [XLEN-1:0]  rf_wd_q;

  logic             active;
  logic             force_b;
  logic             grant_a;
  logic             grant_b;
  logic             beat;
  logic [4:0]       beat_rd;
  logic [XLEN-1:0]  beat_wd;

  always_comb begin
    active  = rst_n && !bus.hold;
    force_b = bus.b_valid && (starve_cnt_q == STARVE_LIM);
    grant_a = active && bus.a_valid && !force_b;
    grant_b = active && bus.b_valid && (force_b || !bus.a_valid);
    beat    = grant_a || grant_b;
    beat_rd = grant_b ? bus.b_rd : bus.a_rd;
    beat_wd = grant_b ? bus.b_wd : bus.a_wd;
  end

  // Counts consecutive refused B cycles; frozen while held with B still waiting.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.b_valid || grant_b) begin
      starve_cnt_d = '0;
    end else if (!bus.hold && (starve_cnt_q != STARVE_LIM)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      rf_we_q      <= 1'b0;
      rf_rd_q      <= '0;
      rf_wd_q      <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rf_we_q      <= beat && (beat_rd != 5'd0);
      if (beat) begin
        rf_rd_q <= beat_rd;
        rf_wd_q <= beat_wd;
      end
    end
  end

  // Outputs are gated by rst_n so a beat accepted just before reset never writes.
  assign bus.a_ready  = grant_a;
  assign bus.b_ready  = grant_b;
  assign bus.b_forced = active && force_b;
  assign bus.rf_we    = rf_we_q && rst_n;
  assign bus.rf_rd    = rst_n ? rf_rd_q : 5'd0;
  assign bus.rf_wd    = rst_n ? rf_wd_q : '0;

endmodule
